// File: rtl/sap_1_pkg.sv
// Shared definitions for the SAP-1 computer: opcodes, ring-counter states,
// debug-select codes, control word and the power-up program image.
package sap_1_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    typedef enum logic [1:0] {
        EO_A      = 2'b00,
        EO_BUS    = 2'b01,
        EO_PC_MAR = 2'b10,
        EO_IR     = 2'b11
    } eo_sel_e;

    typedef struct packed {
        logic pc_out;
        logic pc_inc;
        logic mar_load;
        logic ram_out;
        logic ir_load;
        logic ir_out;
        logic a_out;
        logic a_load;
        logic b_load;
        logic alu_out;
        logic sub;
        logic o_load;
    } ctrl_word_t;

    // LDA 9, ADD A, SUB B, OUT, HLT with data 0x10, 0x14, 0x18
    localparam logic [7:0] DEFAULT_PROG [16] = '{
        8'h09, 8'h1A, 8'h2B, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h10, 8'h14, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00
    };

endpackage

// File: rtl/sap_1_ctrl.sv
// SAP-1 controller: one-hot ring counter, halt flag and control-word decode
// from the current T state and opcode.
module sap_1_ctrl
    import sap_1_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] opcode,
    output t_state_e   t,
    output logic       halted,
    output ctrl_word_t cw
);

    t_state_e t_next;
    logic     hlt_set;

    always_comb begin
        unique case (t)
            T1:      t_next = T2;
            T2:      t_next = T3;
            T3:      t_next = T4;
            T4:      t_next = T5;
            T5:      t_next = T6;
            default: t_next = T1;
        endcase
    end

    // The halting edge also leaves the ring parked on T4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t      <= T1;
            halted <= 1'b0;
        end else if (run && !halted) begin
            if (hlt_set) halted <= 1'b1;
            else         t      <= t_next;
        end
    end

    always_comb begin
        cw      = '0;
        hlt_set = 1'b0;
        unique case (t)
            T1: begin
                cw.pc_out   = 1'b1;
                cw.mar_load = 1'b1;
            end
            T2: cw.pc_inc = 1'b1;
            T3: begin
                cw.ram_out = 1'b1;
                cw.ir_load = 1'b1;
            end
            T4: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        cw.ir_out   = 1'b1;
                        cw.mar_load = 1'b1;
                    end
                    OP_OUT: begin
                        cw.a_out  = 1'b1;
                        cw.o_load = 1'b1;
                    end
                    OP_HLT:  hlt_set = 1'b1;
                    default: ;
                endcase
            end
            T5: begin
                case (opcode)
                    OP_LDA: begin
                        cw.ram_out = 1'b1;
                        cw.a_load  = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw.ram_out = 1'b1;
                        cw.b_load  = 1'b1;
                    end
                    default: ;
                endcase
            end
            T6: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    cw.alu_out = 1'b1;
                    cw.a_load  = 1'b1;
                    cw.sub     = (opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sap_1.sv
// SAP-1 8-bit computer top: datapath registers, W bus, ALU, 16x8 RAM with
// front-panel programming and a selectable debug view.
module sap_1
    import sap_1_pkg::*;
(
    input  logic       clk,
    input  logic       fp_clear,
    input  logic       fp_prog,
    input  logic       fp_write,
    input  logic [3:0] fp_adr,
    input  logic [7:0] fp_data,
    input  logic [1:0] eo_sel,
    output logic [7:0] out_value,
    output logic [7:0] extra_out,
    output logic       halted
);

    logic [3:0] pc;
    logic [3:0] mar;
    logic [7:0] ir;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] o;
    logic [7:0] bus;
    logic [7:0] alu;
    logic       cpu_en;
    t_state_e   t;
    ctrl_word_t cw;

    logic [7:0] ram [16] = DEFAULT_PROG;

    sap_1_ctrl u_ctrl (
        .clk    (clk),
        .rst_n  (fp_clear),
        .run    (!fp_prog),
        .opcode (ir[7:4]),
        .t      (t),
        .halted (halted),
        .cw     (cw)
    );

    assign cpu_en = !fp_prog && !halted;
    assign alu    = cw.sub ? (a - b) : (a + b);

    always_comb begin
        bus = '0;
        if (cw.pc_out)       bus = {4'h0, pc};
        else if (cw.ram_out) bus = ram[mar];
        else if (cw.ir_out)  bus = {4'h0, ir[3:0]};
        else if (cw.a_out)   bus = a;
        else if (cw.alu_out) bus = alu;
    end

    always_ff @(posedge clk) begin
        if (fp_prog && fp_write) ram[fp_adr] <= fp_data;
    end

    always_ff @(posedge clk or negedge fp_clear) begin
        if (!fp_clear) begin
            pc  <= '0;
            mar <= '0;
            ir  <= '0;
            a   <= '0;
            b   <= '0;
            o   <= '0;
        end else if (cpu_en) begin
            if (cw.pc_inc)   pc  <= pc + 4'd1;
            if (cw.mar_load) mar <= bus[3:0];
            if (cw.ir_load)  ir  <= bus;
            if (cw.a_load)   a   <= bus;
            if (cw.b_load)   b   <= bus;
            if (cw.o_load)   o   <= bus;
        end
    end

    assign out_value = o;

    always_comb begin
        unique case (eo_sel_e'(eo_sel))
            EO_A:      extra_out = a;
            EO_BUS:    extra_out = bus;
            EO_PC_MAR: extra_out = {pc, mar};
            default:   extra_out = ir;
        endcase
    end

endmodule

// File: tb/tb_sap_1.sv
// Directed self-checking bench for the SAP-1 computer.
module tb_sap_1;

    logic       clk = 1'b0;
    logic       fp_clear = 1'b0;
    logic       fp_prog = 1'b0;
    logic       fp_write = 1'b0;
    logic [3:0] fp_adr = '0;
    logic [7:0] fp_data = '0;
    logic [1:0] eo_sel = 2'b00;
    logic [7:0] out_value;
    logic [7:0] extra_out;
    logic       halted;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    sap_1 dut (
        .clk       (clk),
        .fp_clear  (fp_clear),
        .fp_prog   (fp_prog),
        .fp_write  (fp_write),
        .fp_adr    (fp_adr),
        .fp_data   (fp_data),
        .eo_sel    (eo_sel),
        .out_value (out_value),
        .extra_out (extra_out),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        fp_clear = 1'b0;
        @(negedge clk);
        fp_clear = 1'b1;
    endtask

    task automatic write_ram(input logic [3:0] adr, input logic [7:0] data);
        fp_adr   = adr;
        fp_data  = data;
        fp_write = 1'b1;
        tick(1);
        fp_write = 1'b0;
    endtask

    task automatic test_reset();
        fp_clear = 1'b0;
        #2;
        eo_sel = 2'b00;
        #1;
        n_total++;
        if (extra_out !== 8'h00) $display("FAIL reset_a got %h want 00", extra_out);
        else n_pass++;
        eo_sel = 2'b10;
        #1;
        n_total++;
        if (extra_out !== 8'h00) $display("FAIL reset_pc_mar got %h want 00", extra_out);
        else n_pass++;
        n_total++;
        if (out_value !== 8'h00 || halted !== 1'b0)
            $display("FAIL reset_out_halt got %h/%b want 00/0", out_value, halted);
        else n_pass++;
    endtask

    task automatic test_default_run();
        do_reset();
        eo_sel = 2'b10;
        tick(1);
        n_total++;
        if (extra_out !== 8'h00) $display("FAIL run_e1_mar got %h want 00", extra_out);
        else n_pass++;
        tick(1);
        n_total++;
        if (extra_out !== 8'h10) $display("FAIL run_e2_pc got %h want 10", extra_out);
        else n_pass++;
        tick(1);
        eo_sel = 2'b11;
        #1;
        n_total++;
        if (extra_out !== 8'h09) $display("FAIL run_e3_ir got %h want 09", extra_out);
        else n_pass++;
        tick(2);
        eo_sel = 2'b00;
        #1;
        n_total++;
        if (extra_out !== 8'h10) $display("FAIL run_e5_a got %h want 10", extra_out);
        else n_pass++;
        tick(17);
        n_total++;
        if (out_value !== 8'h0C) $display("FAIL run_e22_out got %h want 0c", out_value);
        else n_pass++;
        tick(5);
        n_total++;
        if (halted !== 1'b0) $display("FAIL run_e27_not_halted got %b want 0", halted);
        else n_pass++;
        tick(1);
        n_total++;
        if (halted !== 1'b1) $display("FAIL run_e28_halted got %b want 1", halted);
        else n_pass++;
        eo_sel = 2'b10;
        tick(20);
        n_total++;
        if (extra_out[7:4] !== 4'h5 || halted !== 1'b1 || out_value !== 8'h0C)
            $display("FAIL run_halt_hold got pc %h halt %b out %h want 5/1/0c",
                     extra_out[7:4], halted, out_value);
        else n_pass++;
    endtask

    task automatic test_eo_sel();
        eo_sel = 2'b01;
        fp_clear = 1'b0;
        @(negedge clk);
        n_total++;
        if (extra_out !== 8'h00) $display("FAIL eo_bus_t1 got %h want 00", extra_out);
        else n_pass++;
        fp_clear = 1'b1;
        tick(2);
        n_total++;
        if (extra_out !== 8'h09) $display("FAIL eo_bus_t3 got %h want 09", extra_out);
        else n_pass++;
        tick(1);
        eo_sel = 2'b10;
        #1;
        n_total++;
        if (extra_out !== 8'h10) $display("FAIL eo_pc_mar got %h want 10", extra_out);
        else n_pass++;
        eo_sel = 2'b11;
        #1;
        n_total++;
        if (extra_out !== 8'h09) $display("FAIL eo_ir got %h want 09", extra_out);
        else n_pass++;
    endtask

    task automatic test_freeze();
        do_reset();
        tick(4);
        fp_prog = 1'b1;
        tick(10);
        eo_sel = 2'b00;
        #1;
        n_total++;
        if (extra_out !== 8'h00) $display("FAIL freeze_a got %h want 00", extra_out);
        else n_pass++;
        eo_sel = 2'b10;
        #1;
        n_total++;
        if (extra_out !== 8'h19) $display("FAIL freeze_pc_mar got %h want 19", extra_out);
        else n_pass++;
        eo_sel = 2'b01;
        #1;
        n_total++;
        if (extra_out !== 8'h10) $display("FAIL freeze_bus_t5 got %h want 10", extra_out);
        else n_pass++;
        fp_prog = 1'b0;
        eo_sel = 2'b00;
        tick(1);
        n_total++;
        if (extra_out !== 8'h10) $display("FAIL freeze_resume_a got %h want 10", extra_out);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        eo_sel = 2'b00;
        tick(13);
        n_total++;
        if (extra_out !== 8'h24) $display("FAIL midrst_pre_a got %h want 24", extra_out);
        else n_pass++;
        fp_clear = 1'b0;
        #1;
        n_total++;
        if (extra_out !== 8'h00) $display("FAIL midrst_a got %h want 00", extra_out);
        else n_pass++;
        eo_sel = 2'b10;
        #1;
        n_total++;
        if (extra_out !== 8'h00) $display("FAIL midrst_pc_mar got %h want 00", extra_out);
        else n_pass++;
        eo_sel = 2'b11;
        #1;
        n_total++;
        if (extra_out !== 8'h00) $display("FAIL midrst_ir got %h want 00", extra_out);
        else n_pass++;
        @(negedge clk);
        fp_clear = 1'b1;
        eo_sel = 2'b10;
        tick(2);
        n_total++;
        if (extra_out !== 8'h10) $display("FAIL midrst_rerun_pc got %h want 10", extra_out);
        else n_pass++;
        tick(20);
        n_total++;
        if (out_value !== 8'h0C) $display("FAIL midrst_rerun_out got %h want 0c", out_value);
        else n_pass++;
        tick(6);
        n_total++;
        if (halted !== 1'b1) $display("FAIL midrst_rerun_halt got %b want 1", halted);
        else n_pass++;
    endtask

    task automatic test_program_mode();
        fp_prog = 1'b1;
        tick(1);
        fp_clear = 1'b0;
        #1;
        n_total++;
        if (halted !== 1'b0 || out_value !== 8'h00)
            $display("FAIL prog_clear got %b/%h want 0/00", halted, out_value);
        else n_pass++;
        fp_clear = 1'b1;
        write_ram(4'h0, 8'h0F);
        write_ram(4'h1, 8'hE0);
        write_ram(4'h2, 8'hF0);
        write_ram(4'hF, 8'hFF);
        fp_prog = 1'b0;
        do_reset();
        tick(9);
        n_total++;
        if (out_value !== 8'h00) $display("FAIL prog_e9_out got %h want 00", out_value);
        else n_pass++;
        tick(1);
        n_total++;
        if (out_value !== 8'hFF) $display("FAIL prog_e10_out got %h want ff", out_value);
        else n_pass++;
        tick(5);
        n_total++;
        if (halted !== 1'b0) $display("FAIL prog_e15_halt got %b want 0", halted);
        else n_pass++;
        tick(1);
        n_total++;
        if (halted !== 1'b1) $display("FAIL prog_e16_halt got %b want 1", halted);
        else n_pass++;
    endtask

    task automatic test_wrap_arith();
        fp_prog = 1'b1;
        write_ram(4'h0, 8'h08);
        write_ram(4'h1, 8'h19);
        write_ram(4'h2, 8'h0A);
        write_ram(4'h3, 8'h2B);
        write_ram(4'h4, 8'hF0);
        write_ram(4'h8, 8'hFF);
        write_ram(4'h9, 8'h02);
        write_ram(4'hA, 8'h00);
        write_ram(4'hB, 8'h01);
        fp_prog = 1'b0;
        do_reset();
        // A write strobe outside program mode must not reach RAM[8]
        fp_adr = 4'h8;
        fp_data = 8'h55;
        fp_write = 1'b1;
        eo_sel = 2'b00;
        tick(5);
        fp_write = 1'b0;
        n_total++;
        if (extra_out !== 8'hFF) $display("FAIL wrap_lda_ff got %h want ff", extra_out);
        else n_pass++;
        tick(7);
        n_total++;
        if (extra_out !== 8'h01) $display("FAIL wrap_add got %h want 01", extra_out);
        else n_pass++;
        tick(5);
        n_total++;
        if (extra_out !== 8'h00) $display("FAIL wrap_lda_00 got %h want 00", extra_out);
        else n_pass++;
        tick(7);
        n_total++;
        if (extra_out !== 8'hFF) $display("FAIL wrap_sub got %h want ff", extra_out);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_eo_sel();
        test_freeze();
        test_mid_reset();
        test_program_mode();
        test_wrap_arith();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sap_1.md
# sap_1

Complete SAP-1 (Simple-As-Possible) 8-bit educational computer with front-panel programming. It contains a 16×8 RAM, a 4-bit program counter, MAR, IR, A, B and O registers, an add/subtract ALU, a shared 8-bit W bus and a 6-state one-hot ring-counter controller. It is the top of the CPU hierarchy. The front panel loads programs, and a selectable debug output exposes internal state.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on the rising edge.
- fp_clear  in  1  asynchronous, active-low reset (clear) of all CPU state except RAM.
- fp_prog  in  1  1 = program mode: CPU frozen, RAM writable from front panel.
- fp_write  in  1  in program mode, writes fp_data to RAM[fp_adr] on the rising edge.
- fp_adr  in  4  front-panel RAM address.
- fp_data  in  8  front-panel RAM write data.
- eo_sel  in  2  extra_out source select.
- out_value  out  8  O (output) register.
- extra_out  out  8  debug view:
  - 00 = A
  - 01 = W bus
  - 10 = {PC, MAR}
  - 11 = IR
- halted  out  1  1 after HLT executes.

## Operation
- Instruction format: IR[7:4] is the opcode and IR[3:0] is the operand address.
- Opcodes:
  - LDA = 0x0
  - ADD = 0x1
  - SUB = 0x2
  - OUT = 0xE
  - HLT = 0xF
  - All others execute as NOP (T4–T6 idle).
- Ring counter T = T1..T6, one-hot 6 bits, T1 = 000001. It advances one state per cycle and wraps T6 -> T1.
- Per-state control (a single driver per cycle; the bus reads 0x00 when undriven):
  - T1: PC -> bus, MAR loads.
  - T2: PC increments.
  - T3: RAM[MAR] -> bus, IR loads.
  - LDA:
    - T4: IR[3:0] -> bus, MAR loads.
    - T5: RAM -> bus, A loads.
    - T6: idle.
  - ADD and SUB:
    - T4: IR[3:0] -> bus, MAR loads.
    - T5: RAM -> bus, B loads.
    - T6: ALU -> bus, A loads.
  - OUT: T4: A -> bus, O loads. T5 and T6 idle.
  - HLT: T4 sets halted. From then on, the ring, PC and all registers freeze until fp_clear.
- ALU: 8-bit, A+B or A−B (two's complement), modulo 256, no flags.
- PC: 4 bits, wraps 0xF -> 0x0.
- RAM: synchronous write, asynchronous read.
  - Read address is MAR.
  - Power-up contents are a default program:
    - 0:0x09
    - 1:0x1A
    - 2:0x2B
    - 3:0xE0
    - 4:0xF0
    - 9:0x10
    - A:0x14
    - B:0x18
    - all others 0x00
  - fp_clear does not alter RAM.
- Program mode (fp_prog=1):
  - CPU clock-enable is off; the ring, PC, MAR, IR, A, B, O and halted all hold.
  - fp_write=1 writes fp_data to RAM[fp_adr].
  - fp_write is ignored when fp_prog=0.
  - Leaving program mode resumes execution from the held state.

## Timing
- Reset values (asynchronous, while fp_clear=0): PC=0, MAR=0, IR=0, A=0, B=0, O=0, T=T1, halted=0.
- After reset release, cycle n is the n-th rising edge. Instruction k, state Tm completes on edge 6k+m.
- Every instruction takes exactly 6 cycles. HLT takes effect at its T4 edge.
- Register loads are visible the cycle after the edge.
- Control signals and extra_out are combinational from current state.
- Reset asserted mid-instruction aborts it immediately. Execution restarts at T1 with PC=0.
- fp_prog rising mid-instruction freezes in the current T state. Program mode wins over CPU execution in the same cycle.
- fp_clear asserted while fp_prog=1 still resets the CPU state; RAM is unaffected.

## Structure
- Package sap_1_pkg holds:
  - opcode constants (LDA, ADD, SUB, OUT, HLT)
  - one-hot T-state constants
  - eo_sel codes
- One sub-module: sap_1_ctrl (ring counter, halted flag and control-word decode from T and IR[7:4]).
- Registers, bus mux, ALU and RAM live in the top.

## Test plan
- Reset, then run the default program:
  - edge 1: MAR=0.
  - edge 2: PC=1.
  - edge 3: IR=0x09.
  - edge 5: A=0x10.
  - after edge 22: out_value=0x0C.
  - after edge 28: halted=1, and PC stays 5 for 20 more cycles.
- Program mode:
  - With fp_prog=1, write RAM 0:0x0F, 1:0xE0, 2:0xF0, F:0xFF.
  - Drop fp_prog and pulse fp_clear.
  - Required result: out_value=0xFF after edge 10, halted after edge 16.
- Wrap arithmetic:
  - ADD with A=0xFF, B=0x02 gives A=0x01.
  - SUB with A=0x00, B=0x01 gives A=0xFF.
- Reset at edge 14 (mid-instruction): all registers return to 0 and T=T1. The default program then reruns and again yields 0x0C.
- eo_sel:
  - at edge 1 with eo_sel=01, extra_out=0x00 (PC on bus).
  - with eo_sel=10 after edge 3, extra_out=0x10.
  - with eo_sel=11 after edge 3, extra_out=0x09.
- Freeze: raise fp_prog at T5 of LDA. All state holds for 10 cycles. After release, A=0x10 one cycle later.
